// File: rtl/demux2_stream.sv
// demux2_stream: routes one valid/ready input stream to two
// single-entry output channels, counting deliveries per channel.
module demux2_stream #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sel,
  output logic         in_ready,
  output logic [n-1:0] out0_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [n-1:0] out1_data,
  output logic         out1_valid,
  input  logic         out1_ready,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
);

  logic         full0;
  logic         full1;
  logic [n-1:0] hold0;
  logic [n-1:0] hold1;
  logic         drain0;
  logic         drain1;
  logic         acc;
  logic         acc0;
  logic         acc1;
  logic         room;

  // Ready depends only on the selected channel; it is free
  // when empty or when its word leaves on this same edge.
  always_comb begin
    drain0 = full0 & out0_ready;
    drain1 = full1 & out1_ready;
    room   = in_sel ? (~full1 | drain1) : (~full0 | drain0);
    in_ready = rst_n & room;
    acc  = in_valid & in_ready;
    acc0 = acc & ~in_sel;
    acc1 = acc & in_sel;
  end

  // Channel 0 holding register, full flag and delivery count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold0 <= '0;
      full0 <= 1'b0;
      cnt0  <= 8'd0;
    end else begin
      if (acc0)
        hold0 <= in_data;
      full0 <= acc0 | (full0 & ~drain0);
      if (drain0)
        cnt0 <= cnt0 + 8'd1;
    end
  end

  // Channel 1 holding register, full flag and delivery count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold1 <= '0;
      full1 <= 1'b0;
      cnt1  <= 8'd0;
    end else begin
      if (acc1)
        hold1 <= in_data;
      full1 <= acc1 | (full1 & ~drain1);
      if (drain1)
        cnt1 <= cnt1 + 8'd1;
    end
  end

  assign out0_data  = hold0;
  assign out1_data  = hold1;
  assign out0_valid = full0;
  assign out1_valid = full1;

endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed and random checks of demux2_stream
// routing, backpressure, counters and asynchronous reset.
module tb_demux2_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_sel;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int errors = 0;
  int checks = 0;

  demux2_stream #(.n(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_sel(in_sel), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = 16'h0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if ({out0_valid, out1_valid} !== 2'b00 ||
        out0_data !== 16'h0 || out1_data !== 16'h0 ||
        cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b%b d=%h/%h c=%0d/%0d exp 0",
               out0_valid, out1_valid, out0_data, out1_data,
               cnt0, cnt1);
    end
    step();
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_route();
    in_data  = 16'h1234;
    in_sel   = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL route_ready got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 16'h1234) begin
      errors++;
      $display("FAIL route_out1 got v=%b d=%h exp v=1 d=1234",
               out1_valid, out1_data);
    end
    checks++;
    if (out0_valid !== 1'b0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL route_other got v0=%b c1=%0d exp 0 0",
               out0_valid, cnt1);
    end
  endtask

  task automatic test_backpressure();
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;
    checks++;
    if (out1_valid !== 1'b0 || cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL bp_drain1 got v=%b c=%0d exp v=0 c=1",
               out1_valid, cnt1);
    end
    in_data  = 16'hAAAA;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    step();
    in_data = 16'hBBBB;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready0 got=%b exp=0", in_ready);
    end
    step();
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL bp_hold got v=%b d=%h exp v=1 d=aaaa",
               out0_valid, out0_data);
    end
    in_sel = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready1 got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 16'hBBBB ||
        out0_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL bp_land got v1=%b d1=%h d0=%h exp 1 bbbb aaaa",
               out1_valid, out1_data, out0_data);
    end
  endtask

  task automatic test_drain_accept();
    do_reset();
    in_data  = 16'h0001;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    step();
    in_data    = 16'h0002;
    out0_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL da_ready got=%b exp=1", in_ready);
    end
    step();
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 16'h0002 ||
        cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL da_reload got v=%b d=%h c=%0d exp 1 0002 1",
               out0_valid, out0_data, cnt0);
    end
    in_data    = 16'h0777;
    in_sel     = 1'b1;
    in_valid   = 1'b1;
    out0_ready = 1'b1;
    step();
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    checks++;
    if (out0_valid !== 1'b0 || cnt0 !== 8'd2 ||
        out1_valid !== 1'b1 || out1_data !== 16'h0777 ||
        out0_data !== 16'h0002) begin
      errors++;
      $display("FAIL cross got v0=%b c0=%0d v1=%b d1=%h d0=%h",
               out0_valid, cnt0, out1_valid, out1_data, out0_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic        s;
    int          bad;
    do_reset();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      w = 16'h1000 + 16'(i);
      s = i[0];
      in_data  = w;
      in_sel   = s;
      in_valid = 1'b1;
      #1;
      if (in_ready !== 1'b1)
        bad++;
      step();
      if (s == 1'b0 && (out0_valid !== 1'b1 || out0_data !== w))
        bad++;
      if (s == 1'b1 && (out1_valid !== 1'b1 || out1_data !== w))
        bad++;
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stream_words got bad=%0d exp bad=0", bad);
    end
    checks++;
    if (cnt0 !== 8'd150 || cnt1 !== 8'd150) begin
      errors++;
      $display("FAIL stream_cnt got %0d/%0d exp 150/150",
               cnt0, cnt1);
    end
    for (int i = 0; i < 106; i++) begin
      in_data  = 16'h2000 + 16'(i);
      in_sel   = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd150) begin
      errors++;
      $display("FAIL stream_wrap got %0d/%0d exp 0/150",
               cnt0, cnt1);
    end
  endtask

  task automatic test_async_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_data  = 16'h5555;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    step();
    in_data = 16'h6666;
    in_sel  = 1'b1;
    step();
    checks++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_full got v=%b%b exp 11",
               out0_valid, out1_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out0_valid, out1_valid} !== 2'b00 ||
        out0_data !== 16'h0 || out1_data !== 16'h0 ||
        cnt0 !== 8'd0 || cnt1 !== 8'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ar_clear got v=%b%b d=%h/%h c=%0d/%0d r=%b",
               out0_valid, out1_valid, out0_data, out1_data,
               cnt0, cnt1, in_ready);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({out0_valid, out1_valid} !== 2'b00 ||
        cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL ar_release got v=%b%b c=%0d/%0d exp 0",
               out0_valid, out1_valid, cnt0, cnt1);
    end
  endtask

  task automatic test_random();
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          del0;
    int          del1;
    logic        exp_rdy;
    logic        acc;
    logic        d0;
    logic        d1;
    do_reset();
    del0 = 0;
    del1 = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_sel     = 1'($urandom_range(0, 1));
      in_data    = 16'($urandom);
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      #1;
      d0 = (q0.size() > 0) && out0_ready;
      d1 = (q1.size() > 0) && out1_ready;
      exp_rdy = in_sel ? (q1.size() == 0 || d1)
                       : (q0.size() == 0 || d0);
      acc = in_valid && exp_rdy;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_ready c=%0d got=%b exp=%b",
                 c, in_ready, exp_rdy);
      end
      checks++;
      if (out0_valid !== (q0.size() > 0) ||
          (q0.size() > 0 && out0_data !== q0[0])) begin
        errors++;
        $display("FAIL rnd_out0 c=%0d got v=%b d=%h exp v=%b",
                 c, out0_valid, out0_data, q0.size() > 0);
      end
      checks++;
      if (out1_valid !== (q1.size() > 0) ||
          (q1.size() > 0 && out1_data !== q1[0])) begin
        errors++;
        $display("FAIL rnd_out1 c=%0d got v=%b d=%h exp v=%b",
                 c, out1_valid, out1_data, q1.size() > 0);
      end
      step();
      if (d0) begin
        void'(q0.pop_front());
        del0++;
      end
      if (d1) begin
        void'(q1.pop_front());
        del1++;
      end
      if (acc && !in_sel)
        q0.push_back(in_data);
      if (acc && in_sel)
        q1.push_back(in_data);
      checks++;
      if (cnt0 !== 8'(del0) || cnt1 !== 8'(del1)) begin
        errors++;
        $display("FAIL rnd_cnt c=%0d got %0d/%0d exp %0d/%0d",
                 c, cnt0, cnt1, del0 % 256, del1 % 256);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_backpressure();
    test_drain_accept();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
